// File: rtl/noc_alloc_pkg.sv
// noc_alloc_pkg: shared FSM state type and one-hot decode helper for the wormhole allocator.
package noc_alloc_pkg;

    typedef enum logic {ALLOC_IDLE, ALLOC_LOCKED} alloc_state_t;

    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if (oh[i]) r = i;
        return r;
    endfunction

endpackage

// File: rtl/rr_ptr_pick.sv
// rr_ptr_pick: combinational round-robin pick, first set request at or after ptr, wrapping.
module rr_ptr_pick
    import noc_alloc_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] masked;
    logic [N-1:0] src;

    // Requests at or above ptr take precedence; otherwise wrap to the lowest request.
    always_comb begin
        hi_mask = ~((N'(1) << ptr) - N'(1));
        masked  = req & hi_mask;
        src     = |masked ? masked : req;
        gnt     = src & (~src + N'(1));
        idx     = IW'(onehot_to_idx(32'(gnt)));
        any     = |req;
    end

endmodule

// File: rtl/wormhole_out_alloc.sv
// wormhole_out_alloc: round-robin wormhole output-port allocator for a NoC router.
// Optional stall watchdog enabled by defining ALLOC_WDOG_EN.
module wormhole_out_alloc
    import noc_alloc_pkg::*;
#(
    parameter int N_OF_INPUTS = 4,
    parameter int WDOG_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic [N_OF_INPUTS-1:0]         req_valid_i,
    input  logic [N_OF_INPUTS-1:0]         req_head_i,
    input  logic [N_OF_INPUTS-1:0]         req_tail_i,
    output logic [N_OF_INPUTS-1:0]         req_ready_o,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [N_OF_INPUTS-1:0]         grant_o,
    output logic [$clog2(N_OF_INPUTS)-1:0] sel_o,
    output logic                           locked_o,
    output logic                           wdog_err_o
);

    localparam int N  = N_OF_INPUTS;
    localparam int IW = $clog2(N_OF_INPUTS);

    alloc_state_t  state, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  pick_gnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          locked;
    logic          hs;
    logic          wdog_fire;

    rr_ptr_pick #(.N(N), .IW(IW)) u_pick (
        .req (req_valid_i & req_head_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        locked      = state == ALLOC_LOCKED;
        out_valid_o = locked & req_valid_i[sel_q];
        req_ready_o = locked ? grant_q & {N{out_ready_i}} : '0;
        hs          = out_valid_o & out_ready_i;
        grant_o     = grant_q;
        sel_o       = sel_q;
        locked_o    = locked;
        wdog_err_o  = wdog_fire;
    end

    always_comb begin
        state_d = state;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        if (!locked) begin
            if (pick_any) begin
                state_d = ALLOC_LOCKED;
                grant_d = pick_gnt;
                sel_d   = pick_idx;
            end
        end else if ((hs && req_tail_i[sel_q]) || wdog_fire) begin
            state_d = ALLOC_IDLE;
            grant_d = '0;
            sel_d   = '0;
            ptr_d   = (sel_q == IW'(N - 1)) ? '0 : sel_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= ALLOC_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state   <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef ALLOC_WDOG_EN
    localparam int CW = $clog2(WDOG_CYCLES + 1);
    logic [CW-1:0] wcnt;

    assign wdog_fire = locked & ~hs & (wcnt == CW'(WDOG_CYCLES - 1));

    // Held at zero while idle, so a fresh lock always starts counting from zero.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)
            wcnt <= '0;
        else if (!locked || hs || wdog_fire)
            wcnt <= '0;
        else
            wcnt <= wcnt + CW'(1);
    end
`else
    assign wdog_fire = 1'b0;
`endif

endmodule

// File: tb/tb_wormhole_out_alloc.sv
// tb_wormhole_out_alloc: randomized and directed checks against a cycle-level reference model.
module tb_wormhole_out_alloc;

    localparam int N = 4;
    localparam int W = 8;
`ifdef ALLOC_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] h;
        logic [N-1:0] t;
        logic         r;
    } stim_t;

    logic         clk = 1'b0;
    logic         arst_n = 1'b0;
    logic [N-1:0] req_valid = '0, req_head = '0, req_tail = '0;
    logic         out_ready = 1'b0;
    logic [N-1:0] req_ready, grant;
    logic [1:0]   sel;
    logic         out_valid, locked, wdog_err;

    int checks = 0;
    int passes = 0;

    int owner = -1;
    int ptr = 0;
    int cnt = 0;
    logic [12:0] exp_vec;

    wormhole_out_alloc #(.N_OF_INPUTS(N), .WDOG_CYCLES(W)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_valid_i(req_valid), .req_head_i(req_head), .req_tail_i(req_tail),
        .req_ready_o(req_ready), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .grant_o(grant), .sel_o(sel), .locked_o(locked), .wdog_err_o(wdog_err)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] obs();
        return {grant, sel, locked, out_valid, req_ready, wdog_err};
    endfunction

    // Drive one cycle of inputs and predict this cycle's outputs from the model.
    task automatic apply(input stim_t s);
        logic [N-1:0] g, rr;
        logic ov, hs, wd;
        req_valid = s.v; req_head = s.h; req_tail = s.t; out_ready = s.r;
        #1;
        g = '0; rr = '0; ov = 1'b0; wd = 1'b0;
        if (owner >= 0) begin
            g[owner] = 1'b1;
            ov = s.v[owner];
            rr[owner] = s.r;
            hs = ov && s.r;
            wd = WDOG_ON && !hs && cnt == W - 1;
        end
        exp_vec = {g, 2'(owner >= 0 ? owner : 0), owner >= 0, ov, rr, wd};
    endtask

    task automatic advance();
        logic hs;
        bit found;
        @(posedge clk);
        if (owner < 0) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr + k) % N;
                if (!found && req_valid[idx] && req_head[idx]) begin
                    owner = idx; cnt = 0; found = 1;
                end
            end
        end else begin
            hs = req_valid[owner] && out_ready;
            if (hs && req_tail[owner]) begin
                ptr = (owner + 1) % N; owner = -1;
            end else if (WDOG_ON) begin
                if (hs) cnt = 0;
                else if (cnt == W - 1) begin ptr = (owner + 1) % N; owner = -1; end
                else cnt++;
            end
        end
        @(negedge clk);
    endtask

    function automatic stim_t mk(input logic [N-1:0] v, h, t, input logic r);
        stim_t s;
        s.v = v; s.h = h; s.t = t; s.r = r;
        return s;
    endfunction

    task automatic test_reset();
        checks++;
        if (obs() !== 13'd0) $display("FAIL reset_state got %b want %b", obs(), 13'd0);
        else passes++;
        @(negedge clk);
        arst_n = 1'b1;
        owner = -1; ptr = 0; cnt = 0;
    endtask

    task automatic test_rr_basic();
        stim_t s[$];
        s.push_back(mk(4'b1010, 4'b1010, 4'b0000, 1));
        s.push_back(mk(4'b1010, 4'b1000, 4'b0000, 1));
        s.push_back(mk(4'b1010, 4'b1000, 4'b0000, 1));
        s.push_back(mk(4'b1010, 4'b1000, 4'b0010, 1));
        s.push_back(mk(4'b1000, 4'b1000, 4'b0000, 1));
        s.push_back(mk(4'b1000, 4'b1000, 4'b1000, 1));
        s.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1));
        foreach (s[i]) begin
            apply(s[i]);
            checks++;
            if (obs() !== exp_vec) $display("FAIL rr_basic[%0d] got %b want %b", i, obs(), exp_vec);
            else passes++;
            if (i == 1 || i == 5) begin
                checks++;
                if (grant !== (i == 1 ? 4'b0010 : 4'b1000))
                    $display("FAIL rr_basic_grant[%0d] got %b want %b", i, grant, i == 1 ? 4'b0010 : 4'b1000);
                else passes++;
            end
            advance();
        end
    endtask

    task automatic test_single_flit();
        stim_t s[$];
        s.push_back(mk(4'b0100, 4'b0100, 4'b0100, 1));
        s.push_back(mk(4'b0100, 4'b0100, 4'b0100, 1));
        s.push_back(mk(4'b1000, 4'b1000, 4'b1000, 1));
        s.push_back(mk(4'b1000, 4'b1000, 4'b1000, 1));
        s.push_back(mk(4'b0101, 4'b0101, 4'b0101, 1));
        s.push_back(mk(4'b0101, 4'b0101, 4'b0101, 1));
        s.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1));
        foreach (s[i]) begin
            apply(s[i]);
            checks++;
            if (obs() !== exp_vec) $display("FAIL single_flit[%0d] got %b want %b", i, obs(), exp_vec);
            else passes++;
            if (i == 5) begin
                checks++;
                if (grant !== 4'b0001) $display("FAIL single_flit_wrap got %b want 0001", grant);
                else passes++;
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        stim_t s[$];
        s.push_back(mk(4'b0001, 4'b0001, 4'b0000, 0));
        for (int k = 0; k < 10; k++) s.push_back(mk(4'b0111, 4'b0110, 4'b0000, 0));
        s.push_back(mk(4'b0001, 4'b0000, 4'b0000, 1));
        s.push_back(mk(4'b0001, 4'b0000, 4'b0000, 1));
        s.push_back(mk(4'b0001, 4'b0000, 4'b0001, 1));
        s.push_back(mk(4'b0000, 4'b0000, 4'b0000, 1));
        foreach (s[i]) begin
            apply(s[i]);
            checks++;
            if (obs() !== exp_vec) $display("FAIL backpressure[%0d] got %b want %b", i, obs(), exp_vec);
            else passes++;
            advance();
        end
    endtask

    task automatic test_nonhead();
        for (int i = 0; i < 3; i++) begin
            apply(mk(4'b0001, 4'b0000, 4'b0001, 1));
            checks++;
            if (obs() !== exp_vec || locked !== 1'b0 || req_ready !== 4'b0000)
                $display("FAIL nonhead[%0d] got %b want %b", i, obs(), exp_vec);
            else passes++;
            advance();
        end
    endtask

    task automatic test_wdog();
        int pulses = 0;
        apply(mk(4'b0010, 4'b0010, 4'b0000, 1));
        advance();
        for (int i = 0; i < 12; i++) begin
            apply(mk(4'b0000, 4'b0000, 4'b0000, 1));
            checks++;
            if (obs() !== exp_vec) $display("FAIL wdog[%0d] got %b want %b", i, obs(), exp_vec);
            else passes++;
            if (wdog_err) pulses++;
            advance();
        end
        checks++;
        if (pulses !== (WDOG_ON ? 1 : 0)) $display("FAIL wdog_pulses got %0d want %0d", pulses, WDOG_ON ? 1 : 0);
        else passes++;
        // Close out any lock still held so later tests start from a known model state.
        for (int i = 0; i < 2; i++) begin
            apply(mk(4'b0010, 4'b0000, 4'b0010, 1));
            advance();
        end
    endtask

    task automatic test_reset_mid();
        apply(mk(4'b0100, 4'b0100, 4'b0000, 1));
        advance();
        apply(mk(4'b0100, 4'b0000, 4'b0000, 1));
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 13'd0) $display("FAIL reset_mid got %b want %b", obs(), 13'd0);
        else passes++;
        owner = -1; ptr = 0; cnt = 0;
        @(negedge clk);
        arst_n = 1'b1;
        apply(mk(4'b0101, 4'b0101, 4'b0000, 1));
        advance();
        apply(mk(4'b0101, 4'b0101, 4'b0001, 1));
        checks++;
        if (obs() !== exp_vec || grant !== 4'b0001) $display("FAIL reset_mid_regrant got %b want %b", obs(), exp_vec);
        else passes++;
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stim_t s;
            s.v = 4'($urandom);
            s.h = 4'($urandom) & 4'($urandom);
            s.t = 4'($urandom) & 4'($urandom);
            s.r = ($urandom_range(0, 3) != 0);
            apply(s);
            checks++;
            if (obs() !== exp_vec) $display("FAIL random[%0d] got %b want %b", i, obs(), exp_vec);
            else passes++;
            advance();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_rr_basic();
        test_single_flit();
        test_backpressure();
        test_nonhead();
        test_wdog();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
